// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI frame responder.
`timescale 1ns/1ps
package spi_resp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StHeader,
    StPayload,
    StTail
  } resp_state_t;

  localparam logic [7:0] CMD_VIDEO     = 8'h01;
  localparam logic [7:0] CMD_AUDIO     = 8'h02;
  localparam logic [7:0] HDR_VIDEO_DEF = 8'hFF;
  localparam logic [7:0] HDR_AUDIO_DEF = 8'hFE;

endpackage

// File: rtl/spi_frame_responder_if.sv
// SPI pins, byte-source handshakes and status flags of the frame responder.
`timescale 1ns/1ps
interface spi_frame_responder_if;
   logic       SPI_clk;
   logic       chip_select;
   logic       MOSI;
   logic       MISO;
   logic [7:0] vid_data;
   logic       vid_valid;
   logic       vid_ready;
   logic [7:0] aud_data;
   logic       aud_valid;
   logic       aud_ready;
   logic       busy;
   logic       frame_done;
   logic       frame_abort;
   logic       underrun;

   modport master (
      output SPI_clk, chip_select, MOSI, vid_data, vid_valid, aud_data, aud_valid,
      input  MISO, vid_ready, aud_ready, busy, frame_done, frame_abort, underrun
   );

   modport slave (
      input  SPI_clk, chip_select, MOSI, vid_data, vid_valid, aud_data, aud_valid,
      output MISO, vid_ready, aud_ready, busy, frame_done, frame_abort, underrun
   );
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with registered rise/fall strobes aligned to the synced level change.
`timescale 1ns/1ps
module spi_sync_edge #(
   parameter logic ResetVal = 1'b0
) (
   input  logic CLK_40,
   input  logic reset_n,
   input  logic async_sig,
   output logic rise,
   output logic fall
);
   logic meta_q;
   logic sync_q;

   always_ff @(posedge CLK_40 or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= ResetVal;
         sync_q <= ResetVal;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         meta_q <= async_sig;
         sync_q <= meta_q;
         rise   <= meta_q & ~sync_q;
         fall   <= ~meta_q & sync_q;
      end
   end
endmodule

// File: rtl/spi_frame_responder.sv
// SPI mode-0 responder: decodes a command byte, answers with header plus video/audio payload.
`timescale 1ns/1ps
module spi_frame_responder
   import spi_resp_pkg::*;
#(
   parameter int unsigned VIDEO_BYTES = 1200,
   parameter int unsigned AUDIO_BYTES = 64,
   parameter logic [7:0]  HDR_VIDEO   = HDR_VIDEO_DEF,
   parameter logic [7:0]  HDR_AUDIO   = HDR_AUDIO_DEF
) (
   input logic                  CLK_40,
   input logic                  reset_n,
   spi_frame_responder_if.slave bus
);
   localparam int unsigned     CntW   = $clog2(VIDEO_BYTES + 1);
   localparam logic [CntW-1:0] VidLen = CntW'(VIDEO_BYTES);
   localparam logic [CntW-1:0] AudLen = CntW'(AUDIO_BYTES);

   logic sck_rise, sck_fall, cs_rise, cs_fall;
   logic mosi_meta, mosi_sync;

   resp_state_t     state;
   logic [7:0]      cmd_sr;
   logic [7:0]      tx_sr;
   logic [2:0]      bit_cnt;
   logic [CntW-1:0] byte_cnt;
   logic            cmd_full, sel_video, done_seen;
   logic            busy_q, vid_ready_q, aud_ready_q, frame_done_q, frame_abort_q, underrun_q;

   logic [CntW-1:0] frame_len;
   logic            last_byte, src_valid;
   logic [7:0]      src_data;

   spi_sync_edge #(.ResetVal(1'b0)) u_sck_sync (
      .CLK_40    (CLK_40),
      .reset_n   (reset_n),
      .async_sig (bus.SPI_clk),
      .rise      (sck_rise),
      .fall      (sck_fall)
   );

   spi_sync_edge #(.ResetVal(1'b1)) u_cs_sync (
      .CLK_40    (CLK_40),
      .reset_n   (reset_n),
      .async_sig (bus.chip_select),
      .rise      (cs_rise),
      .fall      (cs_fall)
   );

   always_ff @(posedge CLK_40 or negedge reset_n) begin
      if (!reset_n) begin
         mosi_meta <= 1'b0;
         mosi_sync <= 1'b0;
      end else begin
         mosi_meta <= bus.MOSI;
         mosi_sync <= mosi_meta;
      end
   end

   always_comb begin
      frame_len = sel_video ? VidLen : AudLen;
      last_byte = (byte_cnt == frame_len);
      src_valid = sel_video ? bus.vid_valid : bus.aud_valid;
      src_data  = sel_video ? bus.vid_data  : bus.aud_data;
   end

   always_ff @(posedge CLK_40 or negedge reset_n) begin
      if (!reset_n) begin
         state         <= StIdle;
         cmd_sr        <= '0;
         tx_sr         <= '0;
         bit_cnt       <= '0;
         byte_cnt      <= '0;
         cmd_full      <= 1'b0;
         sel_video     <= 1'b0;
         done_seen     <= 1'b0;
         busy_q        <= 1'b0;
         vid_ready_q   <= 1'b0;
         aud_ready_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_abort_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         vid_ready_q   <= 1'b0;
         aud_ready_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_abort_q <= 1'b0;
         // Deselect takes priority over any SCK edge seen in the same cycle.
         if (cs_rise && state != StIdle) begin
            state         <= StIdle;
            tx_sr         <= '0;
            busy_q        <= 1'b0;
            frame_abort_q <= ~done_seen;
         end else begin
            unique case (state)
               StIdle: begin
                  if (cs_fall) begin
                     state      <= StCmd;
                     busy_q     <= 1'b1;
                     tx_sr      <= '0;
                     cmd_sr     <= '0;
                     bit_cnt    <= '0;
                     byte_cnt   <= '0;
                     cmd_full   <= 1'b0;
                     sel_video  <= 1'b0;
                     done_seen  <= 1'b0;
                     underrun_q <= 1'b0;
                  end
               end
               StCmd: begin
                  if (sck_rise && !cmd_full) begin
                     cmd_sr  <= {cmd_sr[6:0], mosi_sync};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) cmd_full <= 1'b1;
                  end else if (sck_fall && cmd_full) begin
                     // The complete byte is acted on at the boundary fall that loads the header.
                     unique case (cmd_sr)
                        CMD_VIDEO: begin
                           sel_video <= 1'b1;
                           tx_sr     <= HDR_VIDEO;
                           state     <= StHeader;
                        end
                        CMD_AUDIO: begin
                           sel_video <= 1'b0;
                           tx_sr     <= HDR_AUDIO;
                           state     <= StHeader;
                        end
                        default: state <= StTail;
                     endcase
                  end
               end
               StHeader, StPayload: begin
                  if (sck_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (state == StPayload && bit_cnt == 3'd7 && last_byte) begin
                        frame_done_q <= 1'b1;
                        done_seen    <= 1'b1;
                     end
                  end else if (sck_fall) begin
                     if (bit_cnt != 3'd0) begin
                        tx_sr <= {tx_sr[6:0], 1'b0};
                     end else if (last_byte) begin
                        state <= StTail;
                        tx_sr <= '0;
                     end else begin
                        state    <= StPayload;
                        byte_cnt <= byte_cnt + CntW'(1);
                        if (src_valid) begin
                           tx_sr       <= src_data;
                           vid_ready_q <= sel_video;
                           aud_ready_q <= ~sel_video;
                        end else begin
                           tx_sr      <= '0;
                           underrun_q <= 1'b1;
                        end
                     end
                  end
               end
               StTail: ;
               default: state <= StIdle;
            endcase
         end
      end
   end

   assign bus.MISO        = tx_sr[7];
   assign bus.busy        = busy_q;
   assign bus.vid_ready   = vid_ready_q;
   assign bus.aud_ready   = aud_ready_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.frame_abort = frame_abort_q;
   assign bus.underrun    = underrun_q;
endmodule

// File: tb/tb_spi_frame_responder.sv
// Directed bench for spi_frame_responder with a MISO byte scoreboard and pulse monitors.
`timescale 1ns/1ps
module tb_spi_frame_responder;
   localparam int HALF = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #12 clk = ~clk;

   spi_frame_responder_if bus ();

   spi_frame_responder #(
      .VIDEO_BYTES (4),
      .AUDIO_BYTES (2),
      .HDR_VIDEO   (8'hFF),
      .HDR_AUDIO   (8'hFE)
   ) dut (
      .CLK_40  (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] vid_mem [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] aud_mem [2] = '{8'h5A, 8'hA5};
   int   vid_idx = 0, aud_idx = 0, vid_pops = 0, aud_pops = 0;
   int   done_cnt = 0, abort_cnt = 0, long_cnt = 0;
   int   drop_slot = -1;
   logic vid_prev = 1'b0, aud_prev = 1'b0;
   logic [7:0] rx;

   // Byte sources behave as FIFOs advanced by the ready strobes.
   always @(negedge clk) begin
      if (bus.vid_ready) begin
         vid_pops++;
         vid_idx++;
         bus.vid_data = vid_mem[vid_idx % 4];
      end
      if (bus.aud_ready) begin
         aud_pops++;
         aud_idx++;
         bus.aud_data = aud_mem[aud_idx % 2];
      end
      if ((bus.vid_ready && vid_prev) || (bus.aud_ready && aud_prev)) long_cnt++;
      vid_prev = bus.vid_ready;
      aud_prev = bus.aud_ready;
      if (bus.frame_done)  done_cnt++;
      if (bus.frame_abort) abort_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Shifts nbits MSB first; valid for payload slot 'slot' is set before the byte's last fall.
   task automatic shift_bits(input logic [7:0] tx, input int nbits, input int slot,
                             output logic [7:0] r);
      r = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         bus.MOSI = tx[7-i];
         wait_clk(HALF);
         bus.SPI_clk = 1'b1;
         r[7-i] = bus.MISO;
         wait_clk(HALF);
         if (i == 7) begin
            bus.vid_valid = (slot != drop_slot);
            bus.aud_valid = (slot != drop_slot);
         end
         bus.SPI_clk = 1'b0;
      end
   endtask

   task automatic start_frame();
      vid_pops = 0; aud_pops = 0; done_cnt = 0; abort_cnt = 0;
      vid_idx = 0; aud_idx = 0;
      bus.vid_data  = vid_mem[0];
      bus.aud_data  = aud_mem[0];
      bus.vid_valid = 1'b1;
      bus.aud_valid = 1'b1;
      bus.chip_select = 1'b0;
      wait_clk(HALF);
   endtask

   // Sends the command, then clocks one response byte per queued expectation.
   task automatic run_cmd(input logic [7:0] cmd);
      logic [7:0] r;
      logic [7:0] e;
      int j;
      shift_bits(cmd, 8, 0, r);
      j = 1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         shift_bits(8'h00, 8, j, r);
         check($sformatf("miso_byte%0d_cmd%0h", j, cmd), {24'h0, r}, {24'h0, e});
         j++;
      end
   endtask

   task automatic end_frame();
      bus.chip_select = 1'b1;
      wait_clk(HALF);
   endtask

   initial begin
      bus.SPI_clk = 1'b0; bus.chip_select = 1'b1; bus.MOSI = 1'b0;
      bus.vid_valid = 1'b1; bus.aud_valid = 1'b1;
      bus.vid_data = vid_mem[0]; bus.aud_data = aud_mem[0];
      wait_clk(5);
      check("rst_miso", bus.MISO, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_vid_ready", bus.vid_ready, 0);
      check("rst_aud_ready", bus.aud_ready, 0);
      check("rst_underrun", bus.underrun, 0);
      check("rst_frame_done", bus.frame_done, 0);
      check("rst_frame_abort", bus.frame_abort, 0);
      rst_n = 1'b1;
      wait_clk(5);

      // Video frame, sources always valid
      exp_q = '{8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
      start_frame();
      check("vid_busy", bus.busy, 1);
      run_cmd(8'h01);
      check("vid_pops", vid_pops, 4);
      check("vid_aud_pops", aud_pops, 0);
      check("vid_done", done_cnt, 1);
      check("vid_underrun", bus.underrun, 0);
      end_frame();
      check("vid_abort", abort_cnt, 0);
      check("vid_busy_end", bus.busy, 0);

      // Audio frame
      exp_q = '{8'hFE, 8'h5A, 8'hA5, 8'h00};
      start_frame();
      run_cmd(8'h02);
      check("aud_pops", aud_pops, 2);
      check("aud_vid_pops", vid_pops, 0);
      check("aud_done", done_cnt, 1);
      end_frame();
      check("aud_abort", abort_cnt, 0);

      // Underrun on the second payload load
      drop_slot = 2;
      exp_q = '{8'hFF, 8'h11, 8'h00, 8'h22, 8'h33, 8'h00};
      start_frame();
      run_cmd(8'h01);
      check("urun_pops", vid_pops, 3);
      check("urun_flag", bus.underrun, 1);
      check("urun_done", done_cnt, 1);
      end_frame();
      check("urun_sticky", bus.underrun, 1);
      drop_slot = -1;

      // Unknown command; the new select also clears underrun
      exp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
      start_frame();
      check("unk_underrun_clr", bus.underrun, 0);
      run_cmd(8'h7E);
      check("unk_vid_pops", vid_pops, 0);
      check("unk_aud_pops", aud_pops, 0);
      check("unk_done", done_cnt, 0);
      check("unk_abort", abort_cnt, 0);
      end_frame();

      // Abort in the middle of payload byte 2
      exp_q = '{8'hFF, 8'h11};
      start_frame();
      run_cmd(8'h01);
      shift_bits(8'h00, 3, 3, rx);
      bus.chip_select = 1'b1;
      wait_clk(HALF);
      check("abort_pulse", abort_cnt, 1);
      check("abort_busy", bus.busy, 0);
      check("abort_miso", bus.MISO, 0);
      check("abort_pops", vid_pops, 2);
      shift_bits(8'h00, 8, 0, rx);
      check("abort_no_pop_after", vid_pops, 2);
      check("abort_done", done_cnt, 0);

      // Reset in the middle of a payload byte
      drop_slot = 1;
      exp_q = '{8'hFF, 8'h00};
      start_frame();
      run_cmd(8'h01);
      shift_bits(8'h00, 3, 3, rx);
      check("mid_underrun_set", bus.underrun, 1);
      bus.SPI_clk = 1'b1;
      wait_clk(2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_miso", bus.MISO, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_underrun", bus.underrun, 0);
      check("mid_rst_vid_ready", bus.vid_ready, 0);
      bus.SPI_clk = 1'b0;
      bus.chip_select = 1'b1;
      drop_slot = -1;
      wait_clk(4);
      rst_n = 1'b1;
      wait_clk(5);
      exp_q = '{8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
      start_frame();
      run_cmd(8'h01);
      check("restart_pops", vid_pops, 4);
      check("restart_done", done_cnt, 1);
      end_frame();

      check("ready_one_cycle", long_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
